// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_e   : FSM state encoding (idle / busy / done)
//   cnt_width : bit-counter width for a given operand width, never below 1
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: computes a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d         : difference bit
//   bout      : borrow-out
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor with borrow: io_out = (io_lhs - io_rhs - io_bin) mod 2^WIDTH,
// one bit per clock, LSB first, with valid/ready on both sides.
//   clk, reset            : clock, asynchronous active-low reset
//   io_in_valid/ready     : operand handshake (io_lhs, io_rhs, io_bin)
//   io_out_valid/ready    : result handshake (io_out, io_bout)
//   io_zero               : difference-is-zero flag, only when SERIAL_SUB_ZERO_FLAG_EN is defined
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_bin,
  input  logic [WIDTH-1:0] io_lhs,
  input  logic [WIDTH-1:0] io_rhs,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_bout
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             io_zero
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lhs_q, lhs_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_bout;
  logic [WIDTH-1:0] res_shift;

  // Operands shift right each busy cycle, so the current bit is always bit 0.
  serial_sub_cell u_cell (
    .a    (lhs_q[0]),
    .b    (rhs_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = cell_d;
  end else begin : g_res_wn
    assign res_shift = {cell_d, res_q[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nz_q, nz_d;      // OR of difference bits produced so far
  logic zero_q, zero_d;
`endif

  always_comb begin
    state_d  = state_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    nz_d     = nz_q;
    zero_d   = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (io_in_valid) begin
          lhs_d    = io_lhs;
          rhs_d    = io_rhs;
          borrow_d = io_bin;
          cnt_d    = '0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          nz_d     = 1'b0;
`endif
          state_d  = StBusy;
        end
      end
      StBusy: begin
        lhs_d    = lhs_q >> 1;
        rhs_d    = rhs_q >> 1;
        borrow_d = cell_bout;
        bout_d   = cell_bout;
        res_d    = res_shift;
        cnt_d    = cnt_q + CntW'(1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        nz_d     = nz_q | cell_d;
`endif
        if (cnt_q == CntLast) begin
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          zero_d  = ~(nz_q | cell_d);
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (io_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      lhs_q    <= '0;
      rhs_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      nz_q   <= nz_d;
      zero_q <= zero_d;
    end
  end

  assign io_zero = zero_q;
`endif

  assign io_in_ready  = (state_q == StIdle);
  assign io_out_valid = (state_q == StDone);
  assign io_out       = res_q;
  assign io_bout      = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor with borrow. It computes io_lhs - io_rhs - io_bin over WIDTH cycles, one bit per clock, LSB first. It is the inverse-direction companion to the team's combinational carry adder: borrow-in and borrow-out replace carry-in and carry-out. Operands are accepted and results returned over valid/ready handshakes, so it can sit behind a producer and in front of a consumer that may stall.

Parameters:
WIDTH, 2, operand and result width in bits (>=1)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
io_in_valid  input  1  operands valid
io_in_ready  output  1  block can accept operands
io_bin  input  1  borrow-in
io_lhs  input  WIDTH  minuend
io_rhs  input  WIDTH  subtrahend
io_out_valid  output  1  result valid
io_out_ready  input  1  consumer accepts result
io_out  output  WIDTH  difference, modulo 2^WIDTH
io_bout  output  1  borrow-out; 1 iff lhs < rhs + bin, unsigned

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - io_in_ready=1, io_out_valid=0, io_out=0, io_bout=0.
  - Operand registers, bit counter and borrow register cleared.
- States:
  - IDLE: io_in_ready=1. On io_in_valid & io_in_ready, latch lhs, rhs and bin, clear the counter and go to BUSY.
  - BUSY: io_in_ready=0. Each edge processes bit i=counter:
    - d = lhs[i] ^ rhs[i] ^ b
    - b' = (~lhs[i] & rhs[i]) | (~(lhs[i] ^ rhs[i]) & b)
    - d shifts into the result register from the MSB side; after WIDTH shifts bit 0 holds the LSB.
    - The counter increments. On the edge processing i=WIDTH-1, go to DONE.
  - DONE: io_out_valid=1, and io_out/io_bout hold the final values. On io_out_ready=1, go to IDLE.
- Latency and throughput:
  - io_out_valid rises exactly WIDTH edges after the accepting edge.
  - io_in_ready returns one edge after the output handshake.
  - Throughput is one operation per WIDTH+2 cycles when io_out_ready=1. Accepting a new operand in the same cycle as the output handshake is not supported.
- io_out and io_bout:
  - Outputs are registered and hold their last result outside DONE.
  - They only change during BUSY.
  - They must be stable while io_out_valid=1 and io_out_ready=0, for any stall length.
- Boundary conditions:
  - io_in_valid outside IDLE is ignored; input values are not sampled.
  - io_out_ready outside DONE has no effect.
  - Wrap-around: io_out = (lhs - rhs - bin) mod 2^WIDTH. Example: 0-0-1 gives all ones with bout=1.
  - WIDTH=1 must work: one BUSY cycle.
  - Reset asserted in BUSY or DONE aborts the operation, discards the result and returns to the reset values.
  - io_in_valid deasserted after the handshake has no effect.

Optional Feature:
SERIAL_SUB_ZERO_FLAG_EN
- Defined: adds output port io_zero (1 bit), registered.
  - io_zero=1 in DONE iff the WIDTH-bit difference is zero; io_bout is not considered.
  - Built as an OR-accumulator cleared on acceptance and updated each BUSY cycle.
  - Reset value 0; held outside DONE like io_out.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - State enum {IDLE, BUSY, DONE} (2-bit encoding).
  - Counter width constant, clog2(WIDTH) with a minimum of 1.
- Natural sub-module serial_sub_cell: combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once.
- Top level holds the FSM, counter, shift registers and handshake.

Test Plan:
- WIDTH=2, lhs=3, rhs=1, bin=0, out_ready=1 -> io_out_valid 2 edges after accept; io_out=2, io_bout=0.
- WIDTH=2, lhs=1, rhs=2, bin=0 -> io_out=3, io_bout=1; then lhs=0, rhs=0, bin=1 -> io_out=3, io_bout=1.
- Backpressure: io_out_ready=0 for 5 cycles in DONE -> io_out_valid stays 1, io_out/io_bout stable, io_in_ready=0; on ready=1 -> IDLE next edge.
- Reset pulse during BUSY (after 1 bit) -> io_out_valid=0, io_out=0, io_in_ready=1 immediately; next operation 2-1-0 gives io_out=1, io_bout=0.
- WIDTH=8 back-to-back random sweep (1000 ops, io_in_valid held high, io_out_ready random) -> every result matches (lhs-rhs-bin) mod 256 and borrow; no op lost or duplicated.
- With SERIAL_SUB_ZERO_FLAG_EN, WIDTH=4: 5-5-0 -> io_zero=1, io_bout=0; 0-15-1 -> io_out=0, io_bout=1, io_zero=1; 7-2-0 -> io_zero=0.
